// File: rtl/bmp280_i2c_target.sv
// I2C target emulating the BMP280 register map: oversampled SCL/SDA, open-drain SDA,
// calibration/ADC data from ports, ctrl_meas/config writable by the bus master.
module bmp280_i2c_target #(
  parameter logic [6:0] I2C_ADDR = 7'h76,
  parameter logic [7:0] CHIP_ID  = 8'h58
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         scl_i,
  input  logic         sda_i,
  output logic         sda_oe,
  input  logic [19:0]  temp_adc,
  input  logic [19:0]  press_adc,
  input  logic [207:0] calib_data,
  output logic [7:0]   ctrl_meas,
  output logic [7:0]   config_reg,
  output logic         soft_reset,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
  } state_t;

  // [0],[1] synchronise; [2] is the previous-sample stage for edge detection
  logic [2:0] scl_q, sda_q;
  logic       scl_s, scl_d, sda_s, sda_d;
  logic       scl_rise, scl_fall, start, stop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign scl_s    = scl_q[1];
  assign scl_d    = scl_q[2];
  assign sda_s    = sda_q[1];
  assign sda_d    = sda_q[2];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [7:0]  sr, sr_n;
  logic        rw, rw_n;
  logic        ack_on, ack_on_n;
  logic        first_byte, first_n;
  logic [7:0]  ptr, ptr_n;
  logic [23:0] shadow_t, sht_n, shadow_p, shp_n;
  logic        oe_n, busy_n;
  logic        wr_en;
  logic [7:0]  rdata;

  always_comb begin
    rdata = 8'h00;
    case (ptr)
      8'hD0:   rdata = CHIP_ID;
      8'hF4:   rdata = ctrl_meas;
      8'hF5:   rdata = config_reg;
      8'hF7:   rdata = shadow_p[23:16];
      8'hF8:   rdata = shadow_p[15:8];
      8'hF9:   rdata = shadow_p[7:0];
      8'hFA:   rdata = shadow_t[23:16];
      8'hFB:   rdata = shadow_t[15:8];
      8'hFC:   rdata = shadow_t[7:0];
      default: rdata = 8'h00;
    endcase
    // 0x88 maps to the top byte of calib_data, ascending address walks downward
    for (int i = 0; i < 26; i++)
      if (ptr == 8'(136 + i)) rdata = calib_data[207 - 8*i -: 8];
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sr_n     = sr;
    rw_n     = rw;
    ack_on_n = ack_on;
    first_n  = first_byte;
    ptr_n    = ptr;
    oe_n     = sda_oe;
    busy_n   = busy;
    sht_n    = shadow_t;
    shp_n    = shadow_p;
    wr_en    = 1'b0;
    if (stop) begin
      state_n  = IDLE;
      oe_n     = 1'b0;
      busy_n   = 1'b0;
      ack_on_n = 1'b0;
    end else if (start) begin
      state_n  = ADDR;
      cnt_n    = 4'd0;
      oe_n     = 1'b0;
      ack_on_n = 1'b0;
    end else begin
      case (state)
        ADDR: if (scl_rise) begin
          sr_n  = {sr[6:0], sda_s};
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            if (sr_n[7:1] == I2C_ADDR) begin
              state_n  = ADDR_ACK;
              rw_n     = sr_n[0];
              busy_n   = 1'b1;
              first_n  = 1'b1;
              ack_on_n = 1'b0;
              if (sr_n[0]) begin
                sht_n = {temp_adc, 4'h0};
                shp_n = {press_adc, 4'h0};
              end
            end else begin
              state_n = WAIT_STOP;
            end
          end
        end
        // ack_on separates the fall that starts the ACK bit from the one ending it
        ADDR_ACK: if (scl_fall) begin
          if (!ack_on) begin
            oe_n     = 1'b1;
            ack_on_n = 1'b1;
          end else begin
            ack_on_n = 1'b0;
            cnt_n    = 4'd0;
            if (rw) begin
              oe_n    = ~rdata[7];
              state_n = RD_BYTE;
            end else begin
              oe_n    = 1'b0;
              state_n = WR_BYTE;
            end
          end
        end
        WR_BYTE: if (scl_rise) begin
          sr_n  = {sr[6:0], sda_s};
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd7) begin
            state_n  = WR_ACK;
            ack_on_n = 1'b0;
            if (first_byte) begin
              ptr_n   = sr_n;
              first_n = 1'b0;
            end else begin
              wr_en = 1'b1;
              ptr_n = ptr + 8'd1;
            end
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!ack_on) begin
            oe_n     = 1'b1;
            ack_on_n = 1'b1;
          end else begin
            oe_n     = 1'b0;
            ack_on_n = 1'b0;
            cnt_n    = 4'd0;
            state_n  = WR_BYTE;
          end
        end
        RD_BYTE: begin
          if (scl_rise) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) begin
              oe_n     = 1'b0;
              ptr_n    = ptr + 8'd1;
              cnt_n    = 4'd0;
              ack_on_n = 1'b0;
              state_n  = RD_ACK;
            end else begin
              oe_n = ~rdata[3'd7 - cnt[2:0]];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s) state_n = WAIT_STOP;
            else       ack_on_n = 1'b1;
          end else if (scl_fall && ack_on) begin
            ack_on_n = 1'b0;
            cnt_n    = 4'd0;
            oe_n     = ~rdata[7];
            state_n  = RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      sr         <= 8'h00;
      rw         <= 1'b0;
      ack_on     <= 1'b0;
      first_byte <= 1'b0;
      ptr        <= 8'h00;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      shadow_t   <= 24'h0;
      shadow_p   <= 24'h0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sr         <= sr_n;
      rw         <= rw_n;
      ack_on     <= ack_on_n;
      first_byte <= first_n;
      ptr        <= ptr_n;
      sda_oe     <= oe_n;
      busy       <= busy_n;
      shadow_t   <= sht_n;
      shadow_p   <= shp_n;
    end
  end

  // the soft_reset pulse itself clears the control registers on the following cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl_meas  <= 8'h00;
      config_reg <= 8'h00;
      soft_reset <= 1'b0;
    end else begin
      soft_reset <= wr_en && (ptr == 8'hE0) && (sr_n == 8'hB6);
      if (soft_reset) begin
        ctrl_meas  <= 8'h00;
        config_reg <= 8'h00;
      end else if (wr_en) begin
        if (ptr == 8'hF4) ctrl_meas  <= sr_n;
        if (ptr == 8'hF5) config_reg <= sr_n;
      end
    end
  end

endmodule

// File: tb/tb_bmp280_i2c_target.sv
// Directed bench for bmp280_i2c_target: bit-banged I2C master with open-drain bus model.
module tb_bmp280_i2c_target;
  localparam int Q = 10;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         scl_m = 1'b1;
  logic         sda_m = 1'b1;
  logic         sda_line;
  logic         sda_oe;
  logic [19:0]  temp_adc = 20'h0;
  logic [19:0]  press_adc = 20'h0;
  logic [207:0] calib_data = '0;
  logic [7:0]   ctrl_meas, cfg;
  logic         soft_reset, busy;

  int total = 0;
  int bad = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  int sr_cnt = 0;

  assign sda_line = sda_m & ~sda_oe;

  bmp280_i2c_target dut (
    .clk(clk), .rstn(rstn), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .temp_adc(temp_adc), .press_adc(press_adc), .calib_data(calib_data),
    .ctrl_meas(ctrl_meas), .config_reg(cfg), .soft_reset(soft_reset), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sda_oe)     oe_cnt   <= oe_cnt + 1;
    if (busy)       busy_cnt <= busy_cnt + 1;
    if (soft_reset) sr_cnt   <= sr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wq();
    scl_m = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic wbit(input logic b);
    sda_m = b; wq();
    scl_m = 1'b1; wq(); wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic rbit(output logic b);
    sda_m = 1'b1; wq();
    scl_m = 1'b1; wq();
    b = sda_line; wq();
    scl_m = 1'b0; wq();
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(ack);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(nack);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         oe0, busy0, sr0;

    repeat (3) @(negedge clk);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_ctrl", {24'd0, ctrl_meas}, 32'h00);
    chk("rst_cfg", {24'd0, cfg}, 32'h00);
    chk("rst_soft", {31'd0, soft_reset}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rstn = 1'b1;
    wq();

    // burst write: pointer F4, then ctrl_meas and config
    i2c_start();
    wbyte(8'hEC, ack); chk("w_addr_ack", {31'd0, ack}, 32'd0);
    chk("w_busy", {31'd0, busy}, 32'd1);
    wbyte(8'hF4, ack); chk("w_ptr_ack", {31'd0, ack}, 32'd0);
    wbyte(8'h27, ack); chk("w_d0_ack", {31'd0, ack}, 32'd0);
    wbyte(8'h14, ack); chk("w_d1_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    chk("ctrl_meas", {24'd0, ctrl_meas}, 32'h27);
    chk("config", {24'd0, cfg}, 32'h14);
    chk("busy_after_stop", {31'd0, busy}, 32'd0);

    // chip id via pointer write + repeated start
    i2c_start();
    wbyte(8'hEC, ack);
    wbyte(8'hD0, ack);
    i2c_rstart();
    wbyte(8'hED, ack); chk("r_addr_ack", {31'd0, ack}, 32'd0);
    rbyte(d, 1'b1); chk("chip_id", {24'd0, d}, 32'h58);
    chk("nack_release", {31'd0, sda_oe}, 32'd0);
    i2c_stop();

    // temperature shadow stays coherent across a live input change
    temp_adc = 20'h81234;
    i2c_start();
    wbyte(8'hEC, ack);
    wbyte(8'hFA, ack);
    i2c_rstart();
    wbyte(8'hED, ack);
    temp_adc = 20'h00000;
    rbyte(d, 1'b0); chk("temp_msb", {24'd0, d}, 32'h81);
    rbyte(d, 1'b0); chk("temp_lsb", {24'd0, d}, 32'h23);
    rbyte(d, 1'b1); chk("temp_xlsb", {24'd0, d}, 32'h40);
    i2c_stop();

    // pressure shadow
    press_adc = 20'hABCDE;
    i2c_start();
    wbyte(8'hEC, ack);
    wbyte(8'hF7, ack);
    i2c_rstart();
    wbyte(8'hED, ack);
    rbyte(d, 1'b0); chk("press_msb", {24'd0, d}, 32'hAB);
    rbyte(d, 1'b0); chk("press_lsb", {24'd0, d}, 32'hCD);
    rbyte(d, 1'b1); chk("press_xlsb", {24'd0, d}, 32'hE0);
    i2c_stop();

    // calibration burst
    for (int i = 0; i < 26; i++) calib_data[207 - 8*i -: 8] = 8'(i);
    i2c_start();
    wbyte(8'hEC, ack);
    wbyte(8'h88, ack);
    i2c_rstart();
    wbyte(8'hED, ack);
    for (int i = 0; i < 26; i++) begin
      rbyte(d, (i == 25));
      chk($sformatf("calib%0d", i), {24'd0, d}, 32'(i));
    end
    i2c_stop();
    chk("calib_ptr_end", {24'd0, dut.ptr}, 32'hA2);

    // wrong address: never driven, never busy
    oe0 = oe_cnt; busy0 = busy_cnt;
    i2c_start();
    wbyte(8'hEE, ack); chk("bad_addr_nack", {31'd0, ack}, 32'd1);
    wbyte(8'h55, ack); chk("bad_data_nack", {31'd0, ack}, 32'd1);
    i2c_stop();
    chk("bad_addr_no_oe", 32'(oe_cnt - oe0), 32'd0);
    chk("bad_addr_no_busy", 32'(busy_cnt - busy0), 32'd0);

    // soft reset
    chk("pre_sr_ctrl", {24'd0, ctrl_meas}, 32'h27);
    sr0 = sr_cnt;
    i2c_start();
    wbyte(8'hEC, ack);
    wbyte(8'hE0, ack);
    wbyte(8'hB6, ack); chk("sr_ack", {31'd0, ack}, 32'd0);
    i2c_stop();
    chk("sr_pulses", 32'(sr_cnt - sr0), 32'd1);
    chk("sr_ctrl", {24'd0, ctrl_meas}, 32'h00);
    chk("sr_cfg", {24'd0, cfg}, 32'h00);

    // async reset while driving read data
    i2c_start();
    wbyte(8'hEC, ack);
    wbyte(8'hD0, ack);
    i2c_rstart();
    wbyte(8'hED, ack);
    chk("mid_rd_drive", {31'd0, sda_oe}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rd_rst_oe", {31'd0, sda_oe}, 32'd0);
    chk("mid_rd_rst_busy", {31'd0, busy}, 32'd0);
    wq();
    rstn = 1'b1;
    oe0 = oe_cnt;
    rbyte(d, 1'b1);
    chk("post_rst_quiet", 32'(oe_cnt - oe0), 32'd0);
    i2c_stop();

    // recovery after reset
    i2c_start();
    wbyte(8'hEC, ack); chk("recov_ack", {31'd0, ack}, 32'd0);
    wbyte(8'hF4, ack);
    wbyte(8'h33, ack);
    i2c_stop();
    chk("recov_ctrl", {24'd0, ctrl_meas}, 32'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bmp280_i2c_target.md
Name: bmp280_i2c_target

Overview:
- Synthesizable I2C target (responder) that emulates the BMP280 register map on the bus side.
- Used as an on-chip loopback partner and simulation model for the BMP280 controller and I2C master.
- Oversamples SCL/SDA in the system clock domain and drives SDA open-drain.
- Serves calibration, temperature and pressure data from input ports, and exposes the ctrl_meas and config registers written by the master.

Parameters:
- I2C_ADDR, 7'h76, 7-bit target address.
- CHIP_ID, 8'h58, value returned at register 0xD0.

Ports:
- clk  in  1  system clock; must be at least 8x the SCL frequency.
- rstn  in  1  asynchronous active-low reset.
- scl_i  in  1  SCL pad input (asynchronous).
- sda_i  in  1  SDA pad input (asynchronous).
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- temp_adc  in  20  raw temperature sample.
- press_adc  in  20  raw pressure sample.
- calib_data  in  208  calibration bytes; register 0x88 = bits [207:200], ascending address = descending byte.
- ctrl_meas  out  8  register 0xF4.
- config  out  8  register 0xF5.
- soft_reset  out  1  one-cycle pulse when 0xB6 is written to 0xE0.
- busy  out  1  high from an address-matched START until STOP.

Behaviour:
- Reset values: sda_oe=0, ctrl_meas=0, config=0, soft_reset=0, busy=0, pointer=0x00, FSM in IDLE.
- Input synchronisation: SCL and SDA each pass through 2 flip-flops, followed by one registered stage for edge detection.
- Bus events:
  - START = synchronised SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.
  - Data bits are sampled on SCL rising edges.
  - sda_oe changes only on the clk cycle after a detected SCL falling edge, except that STOP releases it immediately.
- FSM states and transitions:
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits, MSB first. On a match with {I2C_ADDR, rw} -> ADDR_ACK. On a mismatch -> WAIT_STOP, with SDA never driven.
  - ADDR_ACK: drive SDA low for the 9th bit. Then go to WR_BYTE if rw=0, or RD_BYTE if rw=1. When rw=1, on entry latch shadow_t={temp_adc,4'h0} and shadow_p={press_adc,4'h0}; burst reads stay coherent.
  - WR_BYTE -> WR_ACK after 8 bits. The first data byte of a write transaction loads the pointer. Each later byte writes register[pointer], then the pointer increments.
  - WR_ACK: ACK every byte, including writes to read-only or unmapped addresses (those writes are discarded).
  - RD_BYTE: drive each bit of register[pointer] MSB first. sda_oe = ~bit; it is set on the SCL falling edge ending ADDR_ACK or RD_ACK. After the 8th bit: release SDA, increment the pointer, go to RD_ACK.
  - RD_ACK: sample the master bit on SCL rise. 0 (ACK) -> RD_BYTE. 1 (NACK) -> WAIT_STOP.
  - WAIT_STOP: SDA released; leave only on STOP or START.
- Global events:
  - STOP from any state -> IDLE, busy=0, sda_oe=0.
  - START from any state (repeated start) -> ADDR. The pointer is kept, so write-pointer-then-read works.
- Register map:
  - 0x88..0xA1: calib_data bytes.
  - 0xD0: CHIP_ID.
  - 0xE0: reads 0x00; writing 0xB6 pulses soft_reset and clears ctrl_meas and config next cycle; other values are ignored.
  - 0xF3: status, reads 0x00.
  - 0xF4 / 0xF5: RW.
  - 0xF7..0xF9: shadow_p [23:16], [15:8], [7:0].
  - 0xFA..0xFC: shadow_t [23:16], [15:8], [7:0].
  - All other addresses read 0x00.
- Pointer: 8-bit, wraps 0xFF -> 0x00.
- Simultaneous events: a STOP or START takes priority over bit processing in the same cycle. A soft_reset write and a same-cycle STOP both take effect.
- Reset mid-transaction: the FSM immediately returns to IDLE and SDA is released. The target then ignores the bus until the next START.

Test Plan:
- Write to 0x76: ptr 0xF4, data 0x27, STOP. Required: ACK on all 3 bytes; ctrl_meas=0x27.
- Write ptr 0xD0, repeated START, read 1 byte with NACK. Required: 0x58 returned; sda_oe=0 after the NACK.
- temp_adc=20'h81234, read 3 bytes from 0xFA. Change temp_adc to 20'h00000 after the address ACK. Required: bytes 0x81, 0x23, 0x40.
- Read 26 bytes from 0x88, with calib_data bytes set to 0x00..0x19. Required: bytes returned in sequence; pointer ends at 0xA2.
- Address 0x77 write. Required: NACK; no SDA drive for the whole transfer; busy stays 0.
- Write 0xB6 to 0xE0 after ctrl_meas=0x27. Required: one soft_reset pulse; ctrl_meas=0x00. Also assert rstn low mid-read. Required: sda_oe=0 within the same cycle.
